// File: rtl/spi_cs_arbiter.sv
// Round-robin arbiter that lets four requesters share one SPI master.
// It drives the chip-selects with setup, hold and inter-transaction gap timing.
module spi_cs_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] req_dev,
  input  logic [31:0] req_len,
  input  logic [31:0] req_tx,
  output logic [3:0]  gnt,
  output logic [3:0]  byte_ack,
  output logic [7:0]  rx_data,
  output logic [3:0]  done,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic [7:0]  cs_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_HOLD, S_GAP
  } state_t;

  // The START cycle counts toward chip-select setup time. The start pulse is
  // registered on leaving START, so SETUP itself lasts CS_SETUP-1 cycles.
  localparam logic [7:0] SETUP_LD = 8'((CS_SETUP > 2) ? CS_SETUP - 2 : 0);
  localparam logic [7:0] HOLD_LD  = 8'((CS_HOLD  > 1) ? CS_HOLD  - 1 : 0);
  localparam logic [7:0] GAP_LD   = 8'((GAP      > 1) ? GAP      - 1 : 0);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] g;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic [7:0] cnt;
  logic [7:0] tmr;

  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 2'd3;
      g         <= '0;
      cnt       <= '0;
      tmr       <= '0;
      gnt       <= '0;
      byte_ack  <= '0;
      done      <= '0;
      spi_start <= 1'b0;
      spi_tx    <= '0;
      rx_data   <= '0;
      cs_n      <= '1;
    end else begin
      byte_ack  <= '0;
      done      <= '0;
      spi_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            gnt   <= 4'd1 << win;
            g     <= win;
            ptr   <= win;
            cs_n  <= ~(8'd1 << req_dev[3*win +: 3]);
            cnt   <= (req_len[8*win +: 8] == 8'd0) ? 8'd1 : req_len[8*win +: 8];
            tmr   <= SETUP_LD;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr == 8'd0) state <= S_START;
          else             tmr   <= tmr - 8'd1;
        end
        S_START: begin
          spi_start <= 1'b1;
          spi_tx    <= req_tx[8*g +: 8];
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (spi_done) begin
            rx_data  <= spi_rx;
            byte_ack <= 4'd1 << g;
            cnt      <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              tmr   <= HOLD_LD;
              state <= S_HOLD;
            end else begin
              state <= S_START;
            end
          end
        end
        S_HOLD: begin
          if (tmr == 8'd0) begin
            cs_n  <= '1;
            done  <= 4'd1 << g;
            gnt   <= '0;
            tmr   <= GAP_LD;
            state <= S_GAP;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_GAP: begin
          if (tmr == 8'd0) state <= S_IDLE;
          else             tmr   <= tmr - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
